// File: rtl/conv_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module      : conv_encoder_param
//  Description : Rate-1/3 block convolutional encoder with selectable block
//                length and tail-biting or zero-terminated operation.
//                Consumes W-bit words LSB first and emits three W-bit coded
//                words per W input bits through a one-deep output register.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_encoder_param #(
  parameter int           W    = 8,
  parameter int           K    = 7,
  parameter logic [K-1:0] G0   = 7'o133,
  parameter logic [K-1:0] G1   = 7'o171,
  parameter logic [K-1:0] G2   = 7'o165,
  parameter int           LEN0 = 1056,
  parameter int           LEN1 = 6144
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         len_sel,
  input  logic         term_mode,
  input  logic [W-1:0] tail_word,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_q0,
  output logic [W-1:0] out_q1,
  output logic [W-1:0] out_q2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int            BW           = (W > 1) ? $clog2(W) : 1;
  localparam int            FW           = $clog2(K) + 1;
  localparam logic [12:0]   c_len0       = 13'(LEN0);
  localparam logic [12:0]   c_len1       = 13'(LEN1);
  localparam logic [BW-1:0] c_last_idx   = BW'(W - 1);
  localparam logic [FW-1:0] c_flush_bits = FW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  // Block configuration captured at start
  logic            r_len_sel;
  logic            r_term;
  logic [K-2:0]    r_tail_preset;

  // Encoder memory: r_sr[K-1-i] holds c_i for i = 1..K-1
  logic [K-2:0]    r_sr;
  logic [12:0]     r_cnt;
  logic [FW-1:0]   r_flush_cnt;

  // Held input word
  logic            r_hold_valid;
  logic [W-1:0]    r_hold_data;
  logic [BW-1:0]   r_bit_idx;

  // Coded-bit accumulators
  logic [W-1:0]    r_acc0;
  logic [W-1:0]    r_acc1;
  logic [W-1:0]    r_acc2;
  logic [BW-1:0]   r_acc_cnt;
  logic            r_done;

  logic [K-2:0]    w_tail_preset;
  logic            w_unused_tail;
  logic [12:0]     w_len;
  logic            w_in_bit;
  logic [K-1:0]    w_taps;
  logic            w_d0;
  logic            w_d1;
  logic            w_d2;
  logic            w_acc_full;
  logic            w_out_free;
  logic            w_out_block;
  logic            w_flush_left;
  logic            w_advance;
  logic            w_word_last;
  logic            w_block_end;
  logic            w_pad_emit;
  logic            w_drain_done;
  logic [W-1:0]    w_acc0_set;
  logic [W-1:0]    w_acc1_set;
  logic [W-1:0]    w_acc2_set;

  // Tail-biting preset: c_i takes the i-th most recent bit of the last word
  generate
    for (genvar gi = 1; gi < K; gi++) begin : g_preset
      assign w_tail_preset[K-1-gi] = tail_word[W-gi];
    end
  endgenerate

  // Low tail bits never reach the encoder memory
  assign w_unused_tail = ^tail_word;

  assign w_len        = r_len_sel ? c_len1 : c_len0;
  assign w_in_bit     = (r_state == S_RUN) ? r_hold_data[r_bit_idx] : 1'b0;
  assign w_taps       = {w_in_bit, r_sr};
  assign w_d0         = ^(G0 & w_taps);
  assign w_d1         = ^(G1 & w_taps);
  assign w_d2         = ^(G2 & w_taps);
  assign w_acc_full   = (r_acc_cnt == c_last_idx);
  assign w_out_free   = !out_valid || out_ready;
  assign w_out_block  = w_acc_full && !w_out_free;
  assign w_flush_left = (r_flush_cnt != c_flush_bits);
  assign w_word_last  = (r_bit_idx == c_last_idx);
  assign w_block_end  = (r_state == S_RUN) && w_advance && (r_cnt == w_len - 13'd1);
  assign w_pad_emit   = (r_state == S_FLUSH) && !w_flush_left &&
                        (r_acc_cnt != '0) && w_out_free;
  assign w_drain_done = (r_state == S_DRAIN) && w_out_free;
  assign done         = r_done;

  // A new word may enter only while running and never after the block's last bit
  assign in_ready = (r_state == S_RUN) && !w_block_end &&
                    (!r_hold_valid || (w_advance && w_word_last));

  // Advance one coded bit unless starved of input or blocked by a full output stage
  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      S_RUN:   w_advance = r_hold_valid && !w_out_block;
      S_FLUSH: w_advance = w_flush_left && !w_out_block;
      default: w_advance = 1'b0;
    endcase
  end

  // Insert the current coded bits at the accumulator fill position
  always_comb begin
    w_acc0_set             = r_acc0;
    w_acc1_set             = r_acc1;
    w_acc2_set             = r_acc2;
    w_acc0_set[r_acc_cnt]  = w_d0;
    w_acc1_set[r_acc_cnt]  = w_d1;
    w_acc2_set[r_acc_cnt]  = w_d2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and busy flag
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_RUN;
      S_RUN:   if (w_block_end) w_state_next = r_term ? S_FLUSH : S_DRAIN;
      S_FLUSH: if (!w_flush_left && ((r_acc_cnt == '0) || w_pad_emit)) w_state_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: configuration capture, input hold, shift register, packing, output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_sel     <= 1'b0;
      r_term        <= 1'b0;
      r_tail_preset <= '0;
      r_sr          <= '0;
      r_cnt         <= '0;
      r_flush_cnt   <= '0;
      r_hold_valid  <= 1'b0;
      r_hold_data   <= '0;
      r_bit_idx     <= '0;
      r_acc0        <= '0;
      r_acc1        <= '0;
      r_acc2        <= '0;
      r_acc_cnt     <= '0;
      out_q0        <= '0;
      out_q1        <= '0;
      out_q2        <= '0;
      out_valid     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_len_sel     <= len_sel;
        r_term        <= term_mode;
        r_tail_preset <= w_tail_preset;
      end

      if (r_state == S_LOAD) begin
        r_sr         <= r_term ? '0 : r_tail_preset;
        r_cnt        <= '0;
        r_flush_cnt  <= '0;
        r_hold_valid <= 1'b0;
        r_bit_idx    <= '0;
        r_acc0       <= '0;
        r_acc1       <= '0;
        r_acc2       <= '0;
        r_acc_cnt    <= '0;
      end

      if (in_valid && in_ready) begin
        r_hold_data  <= in_data;
        r_hold_valid <= 1'b1;
        r_bit_idx    <= '0;
      end else if ((r_state == S_RUN) && w_advance) begin
        r_bit_idx <= w_word_last ? '0 : r_bit_idx + BW'(1);
        if (w_word_last) r_hold_valid <= 1'b0;
      end

      if (w_advance) begin
        r_sr <= w_taps[K-1:1];
        if (r_state == S_RUN) r_cnt <= r_cnt + 13'd1;
        else                  r_flush_cnt <= r_flush_cnt + FW'(1);
        if (w_acc_full) begin
          out_q0    <= w_acc0_set;
          out_q1    <= w_acc1_set;
          out_q2    <= w_acc2_set;
          r_acc0    <= '0;
          r_acc1    <= '0;
          r_acc2    <= '0;
          r_acc_cnt <= '0;
        end else begin
          r_acc0    <= w_acc0_set;
          r_acc1    <= w_acc1_set;
          r_acc2    <= w_acc2_set;
          r_acc_cnt <= r_acc_cnt + BW'(1);
        end
      end else if (w_pad_emit) begin
        // Unfilled upper bits are already zero, giving the padded final word
        out_q0    <= r_acc0;
        out_q1    <= r_acc1;
        out_q2    <= r_acc2;
        r_acc0    <= '0;
        r_acc1    <= '0;
        r_acc2    <= '0;
        r_acc_cnt <= '0;
      end

      if ((w_advance && w_acc_full) || w_pad_emit) out_valid <= 1'b1;
      else if (out_ready)                          out_valid <= 1'b0;

      r_done <= w_drain_done;
    end
  end

endmodule
`default_nettype wire

// File: doc/conv_encoder_param.md
CONV_ENCODER_PARAM -- requirements
Module: conv_encoder_param

Interface
REQ-001 SHALL have parameter W, default 8: input/output word width in bits, W >= K-1.
REQ-002 SHALL have parameter K, default 7: constraint length.
REQ-003 SHALL have parameters G0/G1/G2, defaults 7'o133/7'o171/7'o165: generators. Bit K-1-i taps register c_i, where c0 is the current input bit.
REQ-004 SHALL have parameters LEN0 = 1056 and LEN1 = 6144: block lengths in bits, each a multiple of W.
REQ-005 SHALL have the following ports:
  - clk  in  1  sole clock; all logic on the rising edge.
  - reset  in  1  synchronous, active-high.
  - start  in  1  one-cycle block start request.
  - len_sel  in  1  0 = LEN0, 1 = LEN1; sampled at accepted start.
  - term_mode  in  1  0 = tail-biting, 1 = zero-terminated; sampled at accepted start.
  - tail_word  in  W  last input word of the block; sampled at accepted start.
  - in_data  in  W  input word, consumed LSB first.
  - in_valid  in  1  in_data valid.
  - in_ready  out  1  word accepted when in_valid && in_ready.
  - out_q0/out_q1/out_q2  out  W each  coded words; bit i = i-th coded bit of the stream.
  - out_valid  out  1  all three out_q words valid.
  - out_ready  in  1  words consumed when out_valid && out_ready.
  - busy  out  1  block in progress.
  - done  out  1  one-cycle pulse after the last output word is consumed.

Function
REQ-006 States SHALL be IDLE, LOAD, RUN, FLUSH, DRAIN.
REQ-007 In IDLE, start=1 SHALL latch len_sel, term_mode and tail_word, then go to LOAD. start in any other state SHALL be ignored.
REQ-008 LOAD (1 cycle) SHALL preset the state registers.
  - Tail-biting: c_i = tail_word[W-i], for i = 1..K-1.
  - Zero-terminated: all state registers = 0.
  - Then go to RUN.
REQ-009 RUN SHALL process one input bit per advancing cycle, starting at bit 0 of the held word.
  - Outputs per bit: d_j = XOR of (G_j & {c0..c6}).
  - Then shift: c_{i+1} <= c_i.
REQ-010 in_ready SHALL be 1 only in RUN, when no word is held or the held word's last bit advances that cycle.
REQ-011 Advance SHALL stall, with no state change, when no input word is held or the output stage is full.
REQ-012 Each stream's d_j SHALL be packed LSB first into a W-bit accumulator. On the W-th bit, all three words SHALL transfer to the output register and out_valid SHALL rise the next cycle.
REQ-013 The output register SHALL hold one word set. If out_valid && !out_ready when a new set completes, the encoder SHALL stall on that bit.
REQ-014 The bit counter SHALL be 13 bits wide. At count = selected LEN:
  - Tail-biting: go to DRAIN.
  - Zero-terminated: go to FLUSH.
REQ-015 FLUSH SHALL feed K-1 zero input bits through the same datapath. After them, a partial accumulator SHALL be zero-padded in upper bits, emitted as a final word, then go to DRAIN.
REQ-016 Words per stream SHALL be:
  - Tail-biting: LEN/W.
  - Zero-terminated: ceil((LEN+K-1)/W).
REQ-017 DRAIN SHALL wait until the last word is consumed, pulse done for 1 cycle, and return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 An input word held at block end SHALL not exist: in_ready SHALL be 0 outside RUN, and exactly LEN/W words SHALL be consumed per block.
REQ-020 out_valid and out_q* SHALL be stable while out_valid && !out_ready.

Reset
REQ-021 reset=1 SHALL, in any state and mid-block, on the next edge set:
  - state = IDLE.
  - counters, accumulators, c* and held word = 0.
  - out_valid, in_ready, busy, done = 0.
  - out_q* = 0.
REQ-022 Reset SHALL take priority over start in the same cycle. Partial block data SHALL be discarded.

Verification
REQ-023 Bench SHALL cover:
  - Tail-biting, len_sel=0, tail_word=0x00, 132 zero words, out_ready=1 -> exactly 132 word sets, all 0x00, then a single done pulse.
  - Zero-terminated, len_sel=0, first word 0x01, rest 0x00 -> first words q0=0x6D, q1=0x4F, q2=0x57. The 133rd words have bits 7:6 = 0. Total 133 sets.
  - Tail-biting random 1056-bit block, tail_word = last word -> all three streams match the golden model. Final state equals initial state.
  - out_ready toggled 1-of-3 cycles and in_valid randomly gapped -> identical output sequence to the no-stall run. out_q* stable while stalled.
  - start reasserted while busy -> ignored, no output change. Reset asserted mid-RUN (word 50) -> next cycle all outputs 0, busy=0. A new block then encodes correctly.
  - len_sel=1, tail-biting -> 768 word sets. done exactly once, 1 cycle.
